// File: rtl/dwconv_requant_act.sv
// ============================================================================
// dwconv_requant_act: requantizes the depthwise-conv accumulator stream to
// int16 with activation, tags it with a channel index and buffers it in a FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dwconv_requant_act #(
    parameter int CHANNELS   = 256,
    parameter int CH_W       = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic signed [20:0]     in_sum,
    input  logic        [4:0]      cfg_shift,
    input  logic        [1:0]      cfg_act_mode,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic signed [15:0]     out_data,
    output logic        [CH_W-1:0] out_ch,
    output logic                   out_last,
    output logic                   ovf_err,
    output logic        [15:0]     sat_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 16 + CH_W;

    logic        [CH_W-1:0] ch_cnt;

    logic                   s1_valid;
    logic signed [20:0]     s1_x;
    logic        [4:0]      s1_shift;
    logic        [1:0]      s1_mode;
    logic        [CH_W-1:0] s1_ch;

    logic                   s2_valid;
    logic signed [21:0]     s2_r;
    logic        [1:0]      s2_mode;
    logic        [CH_W-1:0] s2_ch;

    logic                   s3_valid;
    logic signed [15:0]     s3_y;
    logic        [CH_W-1:0] s3_ch;
    logic                   s3_sat;

    logic        [4:0]      sh;
    logic signed [21:0]     x_ext;
    logic signed [21:0]     rnd;
    logic signed [21:0]     r_val;
    logic signed [15:0]     c_val;
    logic signed [15:0]     y_val;
    logic                   sat_val;

    // Round half up: add half an LSB of the result before the arithmetic shift.
    always_comb begin
        sh    = (s1_shift > 5'd20) ? 5'd20 : s1_shift;
        x_ext = {s1_x[20], s1_x};
        rnd   = (sh == 5'd0) ? 22'sd0 : (22'sd1 <<< (sh - 5'd1));
        r_val = (x_ext + rnd) >>> sh;
    end

    always_comb begin
        sat_val = 1'b0;
        if (s2_r > 22'sd32767) begin
            c_val   = 16'sh7FFF;
            sat_val = 1'b1;
        end else if (s2_r < -22'sd32768) begin
            c_val   = -16'sd32768;
            sat_val = 1'b1;
        end else begin
            c_val = s2_r[15:0];
        end
        case (s2_mode)
            2'd1:    y_val = c_val[15] ? 16'sd0 : c_val;
            2'd2:    y_val = c_val[15] ? (c_val >>> 3) : c_val;
            default: y_val = c_val;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_cnt   <= '0;
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_shift <= '0;
            s1_mode  <= '0;
            s1_ch    <= '0;
            s2_valid <= 1'b0;
            s2_r     <= '0;
            s2_mode  <= '0;
            s2_ch    <= '0;
            s3_valid <= 1'b0;
            s3_y     <= '0;
            s3_ch    <= '0;
            s3_sat   <= 1'b0;
        end else begin
            if (in_valid) begin
                ch_cnt <= (ch_cnt == CH_W'(CHANNELS - 1)) ? '0 : ch_cnt + CH_W'(1);
            end
            s1_valid <= in_valid;
            s1_x     <= in_sum;
            s1_shift <= cfg_shift;
            s1_mode  <= cfg_act_mode;
            s1_ch    <= ch_cnt;
            s2_valid <= s1_valid;
            s2_r     <= r_val;
            s2_mode  <= s1_mode;
            s2_ch    <= s1_ch;
            s3_valid <= s2_valid;
            s3_y     <= y_val;
            s3_ch    <= s2_ch;
            s3_sat   <= sat_val;
        end
    end

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;
    logic [AW-1:0] rd_next;
    logic [AW:0]   cnt_next;
    logic [EW-1:0] head_next;

    // Output registers hold the head so the last popped value stays visible.
    always_comb begin
        full      = (count == (AW + 1)'(FIFO_DEPTH));
        pop       = out_valid && out_ready;
        push      = s3_valid && (!full || pop);
        drop      = s3_valid && full && !pop;
        rd_next   = rd_ptr + AW'(pop);
        cnt_next  = count + (AW + 1)'(push) - (AW + 1)'(pop);
        head_next = (push && (wr_ptr == rd_next)) ? {s3_y, s3_ch} : mem[rd_next];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {s3_y, s3_ch};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            out_data <= '0;
            out_ch   <= '0;
            ovf_err  <= 1'b0;
            sat_cnt  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_next;
            count  <= cnt_next;
            if (cnt_next != '0) begin
                {out_data, out_ch} <= head_next;
            end
            if (drop) begin
                ovf_err <= 1'b1;
            end
            if (s3_valid && s3_sat && (sat_cnt != 16'hFFFF)) begin
                sat_cnt <= sat_cnt + 16'd1;
            end
        end
    end

    assign out_valid = (count != '0);
    assign out_last  = (out_ch == CH_W'(CHANNELS - 1));

endmodule

`default_nettype wire

// File: tb/tb_dwconv_requant_act.sv
// Directed testbench for dwconv_requant_act.
`default_nettype none

module tb_dwconv_requant_act;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic signed [20:0] in_sum;
    logic        [4:0]  cfg_shift;
    logic        [1:0]  cfg_act_mode;
    logic               out_ready;
    logic               out_valid;
    logic signed [15:0] out_data;
    logic        [7:0]  out_ch;
    logic               out_last;
    logic               ovf_err;
    logic        [15:0] sat_cnt;

    int checks = 0;
    int errors = 0;

    dwconv_requant_act #(.CHANNELS(256), .CH_W(8), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sum(in_sum),
        .cfg_shift(cfg_shift), .cfg_act_mode(cfg_act_mode), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
        .out_last(out_last), .ovf_err(ovf_err), .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_sum = '0; out_ready = 1'b1;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    // One sample in, wait for it at the FIFO head, then let it pop.
    task automatic apply_one(input int sum, output int data, output int lat);
        in_sum = 21'(sum); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = -1; data = 99999;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (out_valid === 1'b1) begin
                lat = k; data = int'(out_data);
                break;
            end
        end
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_sum = '0; out_ready = 1'b0;
        cfg_shift = '0; cfg_act_mode = '0;
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 16'sd0) begin errors++; $display("FAIL reset_data got %0d want 0", out_data); end
        checks++; if (out_ch !== 8'd0) begin errors++; $display("FAIL reset_ch got %0d want 0", out_ch); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", out_last); end
        checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf_err); end
        checks++; if (sat_cnt !== 16'd0) begin errors++; $display("FAIL reset_sat got %0d want 0", sat_cnt); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_rounding();
        int sums [5] = '{256, 24, -24, -25, -7};
        int shs  [5] = '{4, 4, 4, 4, 0};
        int exps [5] = '{16, 2, -1, -2, -7};
        int d, l;
        do_reset();
        cfg_act_mode = 2'd0;
        for (int i = 0; i < 5; i++) begin
            cfg_shift = 5'(shs[i]);
            apply_one(sums[i], d, l);
            checks++; if (d !== exps[i]) begin errors++; $display("FAIL round_%0d got %0d want %0d", i, d, exps[i]); end
            checks++; if (l !== 3) begin errors++; $display("FAIL round_lat_%0d got %0d want 3", i, l); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL round_drain_%0d got %b want 0", i, out_valid); end
        end
        checks++; if (out_data !== -16'sd7) begin errors++; $display("FAIL round_hold got %0d want -7", out_data); end
    endtask

    task automatic test_saturation();
        int d, l;
        do_reset();
        cfg_shift = 5'd0; cfg_act_mode = 2'd0;
        apply_one(32'h000F_FFFF, d, l);
        checks++; if (d !== 32767) begin errors++; $display("FAIL sat_pos got %0d want 32767", d); end
        apply_one(-1048576, d, l);
        checks++; if (d !== -32768) begin errors++; $display("FAIL sat_neg got %0d want -32768", d); end
        checks++; if (sat_cnt !== 16'd2) begin errors++; $display("FAIL sat_cnt2 got %0d want 2", sat_cnt); end
        apply_one(32767, d, l);
        checks++; if (d !== 32767) begin errors++; $display("FAIL sat_edge got %0d want 32767", d); end
        checks++; if (sat_cnt !== 16'd2) begin errors++; $display("FAIL sat_cnt_hold got %0d want 2", sat_cnt); end
    endtask

    task automatic test_activation();
        int modes [7] = '{1, 1, 2, 2, 2, 2, 3};
        int sums  [7] = '{-80, 80, -80, -1, -9, 5, -80};
        int exps  [7] = '{0, 80, -10, -1, -2, 5, -80};
        int d, l;
        do_reset();
        cfg_shift = 5'd0;
        for (int i = 0; i < 7; i++) begin
            cfg_act_mode = 2'(modes[i]);
            apply_one(sums[i], d, l);
            checks++; if (d !== exps[i]) begin errors++; $display("FAIL act_%0d got %0d want %0d", i, d, exps[i]); end
        end
        checks++; if (sat_cnt !== 16'd0) begin errors++; $display("FAIL act_sat got %0d want 0", sat_cnt); end
    endtask

    task automatic test_overflow();
        do_reset();
        cfg_shift = 5'd0; cfg_act_mode = 2'd0; out_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            in_sum = 21'(i); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", ovf_err); end
        checks++; if (out_data !== 16'sd1) begin errors++; $display("FAIL ovf_head got %0d want 1", out_data); end
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'(k)) begin
                errors++; $display("FAIL ovf_drain_%0d got v=%b d=%0d want v=1 d=%0d", k, out_valid, out_data, k);
            end
            step();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b want 0", out_valid); end
        checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", ovf_err); end
    endtask

    task automatic test_back_to_back();
        int got [$];
        do_reset();
        cfg_shift = 5'd0; cfg_act_mode = 2'd0; out_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            in_valid = (i < 20); in_sum = 21'(i + 1);
            out_ready = (i >= 11);
            if (out_valid === 1'b1 && out_ready) got.push_back(int'(out_data));
            step();
        end
        checks++; if (got.size() !== 20) begin errors++; $display("FAIL b2b_count got %0d want 20", got.size()); end
        for (int k = 0; k < 20 && k < got.size(); k++) begin
            checks++; if (got[k] !== k + 1) begin errors++; $display("FAIL b2b_%0d got %0d want %0d", k, got[k], k + 1); end
        end
        checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL b2b_ovf got %b want 0", ovf_err); end
    endtask

    task automatic test_channel_wrap();
        int chs [$];
        int lasts [$];
        do_reset();
        cfg_shift = 5'd0; cfg_act_mode = 2'd0; out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_valid = (i < 257); in_sum = 21'(i);
            if (out_valid === 1'b1) begin chs.push_back(int'(out_ch)); lasts.push_back(int'(out_last)); end
            step();
        end
        in_valid = 1'b0;
        checks++; if (chs.size() !== 257) begin errors++; $display("FAIL wrap_count got %0d want 257", chs.size()); end
        for (int k = 0; k < chs.size() && k < 257; k++) begin
            checks++; if (chs[k] !== k % 256) begin errors++; $display("FAIL wrap_ch_%0d got %0d want %0d", k, chs[k], k % 256); end
            checks++; if (lasts[k] !== int'(k == 255)) begin errors++; $display("FAIL wrap_last_%0d got %0d want %0d", k, lasts[k], int'(k == 255)); end
        end
    endtask

    task automatic test_reset_midstream();
        int d, l;
        do_reset();
        cfg_shift = 5'd0; cfg_act_mode = 2'd0; out_ready = 1'b1;
        in_sum = 21'sd100000; in_valid = 1'b1;
        for (int i = 0; i < 100; i++) step();
        checks++; if (sat_cnt === 16'd0) begin errors++; $display("FAIL mid_pre_sat got %0d want nonzero", sat_cnt); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 16'sd0) begin errors++; $display("FAIL mid_data got %0d want 0", out_data); end
        checks++; if (out_ch !== 8'd0) begin errors++; $display("FAIL mid_ch got %0d want 0", out_ch); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL mid_last got %b want 0", out_last); end
        checks++; if (sat_cnt !== 16'd0) begin errors++; $display("FAIL mid_sat got %0d want 0", sat_cnt); end
        in_valid = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        apply_one(5, d, l);
        checks++; if (d !== 5) begin errors++; $display("FAIL mid_after_data got %0d want 5", d); end
        checks++; if (out_ch !== 8'd0) begin errors++; $display("FAIL mid_after_ch got %0d want 0", out_ch); end
        checks++; if (l !== 3) begin errors++; $display("FAIL mid_after_lat got %0d want 3", l); end
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_saturation();
        test_activation();
        test_overflow();
        test_back_to_back();
        test_channel_wrap();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
